// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase toggle req/ack CDC handshake.
// in_valid/in_ready: a word transfers on any posedge where both are high; in_ready is high only in IDLE.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req_tgl,
    output logic [DATA_W-1:0] tx_data,
    input  logic              ack_tgl,
    output logic              done,
    output logic              busy,
    output logic              timeout_err,
    output logic              protocol_err
);

    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       wait_cnt;
    logic [SYNC_STAGES-1:0] ack_meta;
    logic                   ack_sync;

    // First stage samples ack_tgl directly: nothing combinational ahead of the synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= '0;
        end else begin
            ack_meta <= {ack_meta[SYNC_STAGES-2:0], ack_tgl};
        end
    end

    assign ack_sync = ack_meta[SYNC_STAGES-1];
    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_tgl      <= 1'b0;
            tx_data      <= '0;
            wait_cnt     <= '0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // With nothing outstanding the toggles must agree; a difference is a stray ack.
                    if (ack_sync != req_tgl) begin
                        protocol_err <= 1'b1;
                    end
                    if (in_valid) begin
                        tx_data  <= in_data;
                        req_tgl  <= ~req_tgl;
                        wait_cnt <= '0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_sync == req_tgl) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        if (wait_cnt != CNT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        // Late acks still complete; the error only records that the wait ran long.
                        if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tx_hold_stable: assert property (@(posedge clk) disable iff (rst)
        $past(busy) |-> ($stable(tx_data) && $stable(req_tgl)));

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed scenarios with literal checks, then random traffic
// compared every cycle against a transaction-level model of the handshake.
module tb_cdc_handshake_tx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 64;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              ack_tgl  = 1'b0;
    logic              in_ready;
    logic              req_tgl;
    logic [DATA_W-1:0] tx_data;
    logic              done;
    logic              busy;
    logic              timeout_err;
    logic              protocol_err;

    cdc_handshake_tx #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .req_tgl(req_tgl),
        .tx_data(tx_data),
        .ack_tgl(ack_tgl),
        .done(done),
        .busy(busy),
        .timeout_err(timeout_err),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int total     = 0;
    int bad       = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            if (bad <= 40) begin
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
            end
        end
    endtask

    // Transaction-level model: outstanding flag, parity of accepted words, ack seen
    // SYNC_STAGES edges late, count of unanswered waiting edges.
    bit                m_busy;
    bit                m_req;
    bit                m_done;
    bit                m_tout;
    bit                m_perr;
    int                m_wait;
    logic [DATA_W-1:0] m_data;
    bit                hist[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic model_reset();
        m_busy = 1'b0;
        m_req  = 1'b0;
        m_done = 1'b0;
        m_tout = 1'b0;
        m_perr = 1'b0;
        m_wait = 0;
        m_data = '0;
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit a);
        bit seen;
        seen = hist.pop_front();
        hist.push_back(a);
        m_done = 1'b0;
        if (!m_busy) begin
            if (seen != m_req) m_perr = 1'b1;
            if (v) begin
                exp_q.push_back(d);
                m_data = d;
                m_req  = !m_req;
                m_busy = 1'b1;
                m_wait = 0;
            end
        end else if (seen == m_req) begin
            m_done = 1'b1;
            m_busy = 1'b0;
        end else begin
            m_wait++;
            if (TIMEOUT != 0 && m_wait == TIMEOUT) m_tout = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(in_valid, in_data, ack_tgl);
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", 32'(in_ready), 32'(!m_busy));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("req_tgl", 32'(req_tgl), 32'(m_req));
                chk("tx_data", 32'(tx_data), 32'(m_data));
                chk("done", 32'(done), 32'(m_done));
                chk("timeout_err", 32'(timeout_err), 32'(m_tout));
                chk("protocol_err", 32'(protocol_err), 32'(m_perr));
                if (done === 1'b1) done_seen++;
                if (m_done && exp_q.size() > 0) chk("done_word", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Destination stand-in: 0 = hold, 1 = echo req after a delay, 2 = drive ack_force.
    int ack_mode   = 0;
    bit ack_force  = 1'b0;
    int ack_delay  = 3;
    int ack_cnt    = 0;
    bit rand_delay = 1'b0;
    int max_delay  = 8;
    int spur_pct   = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                ack_tgl = 1'b0;
                ack_cnt = 0;
            end else begin
                case (ack_mode)
                    1: begin
                        if (req_tgl != ack_tgl) begin
                            if (ack_cnt >= ack_delay) begin
                                ack_tgl = req_tgl;
                                ack_cnt = 0;
                                if (rand_delay) ack_delay = int'($urandom_range(0, max_delay));
                            end else begin
                                ack_cnt++;
                            end
                        end else begin
                            ack_cnt = 0;
                            if (spur_pct != 0 && $urandom_range(0, 99) < spur_pct) ack_tgl = ~ack_tgl;
                        end
                    end
                    2: ack_tgl = ack_force;
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        ticks(3);
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int done_base;
        ticks(3);
        rst = 1'b0;

        // Reset then idle
        ticks(20);
        chk("idle_ready", 32'(in_ready), 1);
        chk("idle_req", 32'(req_tgl), 0);
        chk("idle_tx", 32'(tx_data), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_tout", 32'(timeout_err), 0);
        chk("idle_perr", 32'(protocol_err), 0);

        // Single transfer, ack raised five cycles after launch
        ack_mode = 0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h5A;
        chk("single_req", 32'(req_tgl), 1);
        chk("single_tx", 32'(tx_data), 32'hA5);
        chk("single_busy", 32'(busy), 1);
        chk("single_ready", 32'(in_ready), 0);
        chk("model_req_pin", 32'(m_req), 1);
        ticks(4);
        ack_force = 1'b1;
        ack_mode  = 2;
        tick();
        chk("single_done_e1", 32'(done), 0);
        tick();
        chk("single_done_e2", 32'(done), 0);
        chk("single_tx_hold", 32'(tx_data), 32'hA5);
        tick();
        chk("single_done_e3", 32'(done), 1);
        chk("single_tx_done", 32'(tx_data), 32'hA5);
        chk("single_ready_done", 32'(in_ready), 1);
        chk("model_done_pin", 32'(m_done), 1);
        tick();
        chk("single_done_once", 32'(done), 0);

        // Back-to-back with echoed ack
        ack_mode   = 1;
        ack_delay  = 3;
        rand_delay = 1'b0;
        do_reset();
        done_base = done_seen;
        chk("b2b_req_start", 32'(req_tgl), 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            chk("b2b_ready_wait", 32'(ok), 1);
            if (i > 0) chk("b2b_accept_in_done", 32'(done), 1);
            tick();
            chk("b2b_req", 32'(req_tgl), 32'((i % 2) == 0));
            chk("b2b_tx", 32'(tx_data), 32'(i + 1));
        end
        in_valid = 1'b0;
        ticks(20);
        chk("b2b_done_count", 32'(done_seen - done_base), 3);

        // Timeout with no ack, then a late ack at cycle 100
        ack_mode = 0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        chk("to_req", 32'(req_tgl), 0);
        chk("to_tx", 32'(tx_data), 32'h3C);
        ticks(63);
        chk("to_not_yet", 32'(timeout_err), 0);
        chk("to_busy63", 32'(busy), 1);
        tick();
        chk("to_set", 32'(timeout_err), 1);
        chk("to_busy64", 32'(busy), 1);
        chk("model_tout_pin", 32'(m_tout), 1);
        ticks(36);
        ack_force = 1'b0;
        ack_mode  = 2;
        ticks(3);
        chk("to_late_done", 32'(done), 1);
        chk("to_sticky", 32'(timeout_err), 1);

        // Spurious ack while idle
        tick();
        chk("sp_perr_before", 32'(protocol_err), 0);
        ack_force = 1'b1;
        tick();
        chk("sp_perr_e1", 32'(protocol_err), 0);
        tick();
        chk("sp_perr_e2", 32'(protocol_err), 0);
        tick();
        chk("sp_perr_e3", 32'(protocol_err), 1);
        chk("sp_no_done", 32'(done), 0);
        chk("sp_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        ticks(3);

        // Async reset mid-transfer
        ack_mode   = 1;
        ack_delay  = 0;
        in_valid   = 1'b1;
        in_data    = 8'h11;
        tick();
        in_valid   = 1'b0;
        ticks(8);
        ack_mode   = 0;
        in_valid   = 1'b1;
        in_data    = 8'hFF;
        tick();
        in_valid   = 1'b0;
        chk("rm_req", 32'(req_tgl), 1);
        chk("rm_tx", 32'(tx_data), 32'hFF);
        chk("rm_busy", 32'(busy), 1);
        ticks(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rm_req_rst", 32'(req_tgl), 0);
        chk("rm_tx_rst", 32'(tx_data), 0);
        chk("rm_busy_rst", 32'(busy), 0);
        chk("rm_ready_rst", 32'(in_ready), 1);
        chk("rm_done_rst", 32'(done), 0);
        chk("rm_tout_rst", 32'(timeout_err), 0);
        chk("rm_perr_rst", 32'(protocol_err), 0);
        ticks(2);
        rst = 1'b0;
        tick();
        chk("rm_ready_after", 32'(in_ready), 1);

        // Random traffic
        ack_mode   = 1;
        rand_delay = 1'b1;
        max_delay  = 8;
        spur_pct   = 2;
        for (int c = 0; c < 2000; c++) begin
            if (c == 800) begin
                max_delay = 80;
                spur_pct  = 0;
            end
            if (c == 1200) begin
                max_delay = 8;
                spur_pct  = 3;
            end
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = 8'($urandom);
            if (c % 700 == 699) begin
                #2 rst = 1'b1;
                ticks(2);
                rst = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        spur_pct  = 0;
        max_delay = 4;
        ticks(120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
- Source-side (transmitter) end of a two-phase toggle request/acknowledge CDC handshake, running entirely in the source clock domain.
- Accepts a data word via valid/ready, launches it across the domain boundary as a held-stable data bus plus a request toggle, and waits for the returned acknowledge toggle from the destination domain.
- Synchronizes the acknowledge internally and signals completion.
- Pairs with a destination-side toggle-to-pulse receiver.

Parameters:
- DATA_W, 8, width of transferred data word.
- SYNC_STAGES, 2, flops in ack synchronizer chain (legal >= 2).
- TIMEOUT, 64, cycles in WAIT_ACK before timeout_err sets; 0 disables timeout.

Ports:
- clk  input  1  source-domain clock, posedge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream has a word to send.
- in_data  input  DATA_W  word to send, sampled on accept.
- in_ready  output  1  block can accept a word.
- req_tgl  output  1  request toggle to destination domain; flips once per transfer.
- tx_data  output  DATA_W  registered data bus to destination; stable from req flip until done.
- ack_tgl  input  1  acknowledge toggle from destination domain; asynchronous to clk.
- done  output  1  one-cycle pulse: transfer acknowledged.
- busy  output  1  transfer outstanding (state WAIT_ACK).
- timeout_err  output  1  sticky: ack not received within TIMEOUT cycles.
- protocol_err  output  1  sticky: ack toggle seen with no transfer outstanding.

Behaviour:
- Reset (async assert, sync release): state IDLE; req_tgl=0, tx_data=0, all sync flops=0, done=0, busy=0, timeout_err=0, protocol_err=0, timeout counter=0.
- ack_sync = last stage of SYNC_STAGES flop chain on ack_tgl. No logic is placed before the first stage.
- in_ready = (state==IDLE), combinational from state. busy = (state==WAIT_ACK).
- States: IDLE, WAIT_ACK.
- IDLE, when in_valid && in_ready at a posedge:
  - tx_data <= in_data.
  - req_tgl <= ~req_tgl.
  - counter <= 0.
  - Next state WAIT_ACK.
  - Otherwise remain in IDLE.
- WAIT_ACK, when ack_sync == req_tgl at a posedge: done <= 1 for exactly one cycle; next state IDLE.
- WAIT_ACK, otherwise: counter increments, saturating. When TIMEOUT != 0 and counter reaches TIMEOUT-1 (i.e. the TIMEOUT-th waiting cycle), timeout_err <= 1. The state stays WAIT_ACK; a late ack still completes normally.
- Latency: an ack_tgl edge first sampled at posedge N gives ack_sync valid after posedge N+SYNC_STAGES-1 and done=1 after posedge N+SYNC_STAGES.
- done is high in the same cycle in_ready is high. An accept in that cycle is legal, so back-to-back transfers have no idle gap.
- tx_data and req_tgl change only on accept. tx_data is never modified in WAIT_ACK.
- protocol_err <= 1 when state==IDLE and ack_sync != req_tgl, i.e. a spurious ack. The spurious ack is otherwise ignored. The next accept flips req_tgl, so the two toggles then mismatch and the transfer waits until ack_sync matches again.
- Sticky errors clear only on rst.
- in_data/in_valid changes while in WAIT_ACK are ignored.
- Reset mid-transfer: all state is dropped immediately and req_tgl returns to 0. The destination must be reset together with this block.
- Counter width: $clog2(TIMEOUT+1), minimum 1.

Test Plan:
- Reset then idle: rst pulse, no stimulus for 20 cycles -> in_ready=1, req_tgl=0, tx_data=0, done=0, busy=0, both errors 0.
- Single transfer, SYNC_STAGES=2: in_valid=1, in_data=0xA5 for one cycle -> next cycle req_tgl=1, tx_data=0xA5, busy=1, in_ready=0. Bench toggles ack_tgl to 1 five cycles later -> done=1 exactly 2 posedges after first sampling edge, for one cycle; tx_data stays 0xA5 throughout.
- Back-to-back: words 0x01, 0x02, 0x03 with in_valid held high, bench echoes req_tgl to ack_tgl after 3 cycles -> req_tgl toggles 0->1->0->1, each new accept occurs in the done cycle, three done pulses, tx_data sequence 0x01, 0x02, 0x03.
- Timeout: TIMEOUT=64, accept 0x3C, ack never toggles -> timeout_err=1 after the 64th WAIT_ACK cycle, busy stays 1. Toggling ack at cycle 100 -> done pulse, timeout_err remains 1.
- Spurious ack: in IDLE with req_tgl=0, toggle ack_tgl to 1 -> protocol_err=1 after SYNC_STAGES+1 posedges, no done, state IDLE.
- Async reset mid-transfer: accept 0xFF, assert rst between clock edges before ack -> outputs return to reset values immediately (no clock needed), in_ready=1 after rst deasserts.
